// File: rtl/alu_a_operand_stage_pkg.sv
// Shared opcode and reset constants for the ALU operand-A decode/execute stage.
// Also provides the "does this instruction read rs1" predicate used by the stall-refresh path.
package alu_a_operand_stage_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_2000;

  typedef enum logic [1:0] {
    UPD_RESET,
    UPD_FLUSH,
    UPD_STALL,
    UPD_LOAD
  } upd_e;

  // LUI/AUIPC/JAL carry immediate bits in the rs1 field, so they never read a register.
  function automatic logic reads_rs1(input logic [6:0] opc, input logic [4:0] rs1);
    return (rs1 != 5'd0) && (opc != OPC_LUI) && (opc != OPC_AUIPC) && (opc != OPC_JAL);
  endfunction

endpackage

// File: rtl/alu_a_operand_stage_rs1_fwd_resolve.sv
// Combinational rs1 resolver: x0 reads as zero, then the nearer forwarding source,
// then the farther one, then the fallback value supplied by the caller.
module rs1_fwd_resolve (
  input  logic [4:0]  i_rs1_idx,
  input  logic [31:0] i_fallback,
  input  logic        i_fwd0_we,
  input  logic [4:0]  i_fwd0_rd,
  input  logic [31:0] i_fwd0_data,
  input  logic        i_fwd1_we,
  input  logic [4:0]  i_fwd1_rd,
  input  logic [31:0] i_fwd1_data,
  output logic [31:0] o_value,
  output logic        o_hit
);

  logic w_hit0;
  logic w_hit1;

  // A source with rd==0 can never match because idx==0 is filtered first.
  assign w_hit0 = i_fwd0_we && (i_fwd0_rd == i_rs1_idx);
  assign w_hit1 = i_fwd1_we && (i_fwd1_rd == i_rs1_idx);

  always_comb begin
    o_value = i_fallback;
    o_hit   = 1'b0;
    if (i_rs1_idx == 5'd0) begin
      o_value = 32'd0;
    end else if (w_hit0) begin
      o_value = i_fwd0_data;
      o_hit   = 1'b1;
    end else if (w_hit1) begin
      o_value = i_fwd1_data;
      o_hit   = 1'b1;
    end
  end

endmodule

// File: rtl/alu_a_operand_stage.sv
// Decode-to-execute register for ALU operand A with rs1 forwarding, stall, flush,
// and refresh of a stalled instruction's rs1 while later stages keep retiring.
module alu_a_operand_stage
  import alu_a_operand_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_inst,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs1_data,
  input  logic        a_sel,
  input  logic        stall,
  input  logic        flush,
  input  logic        fwd0_we,
  input  logic [4:0]  fwd0_rd,
  input  logic [31:0] fwd0_data,
  input  logic        fwd1_we,
  input  logic [4:0]  fwd1_rd,
  input  logic [31:0] fwd1_data,
  output logic        ex_valid,
  output logic [31:0] ex_inst,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_alu_a,
  output logic [31:0] ex_rs1
);

  logic        r_valid;
  logic [31:0] r_inst;
  logic [31:0] r_pc;
  logic [31:0] r_alu_a;
  logic [31:0] r_rs1;
  logic        r_a_sel;

  logic [31:0] w_id_rs1;
  logic        w_id_hit;
  logic [31:0] w_id_alu_a;
  logic [31:0] w_ex_rs1;
  logic        w_ex_hit;
  logic        w_refresh;
  upd_e        w_upd;

  rs1_fwd_resolve u_id_resolve (
    .i_rs1_idx   (id_inst[19:15]),
    .i_fallback  (id_rs1_data),
    .i_fwd0_we   (fwd0_we),
    .i_fwd0_rd   (fwd0_rd),
    .i_fwd0_data (fwd0_data),
    .i_fwd1_we   (fwd1_we),
    .i_fwd1_rd   (fwd1_rd),
    .i_fwd1_data (fwd1_data),
    .o_value     (w_id_rs1),
    .o_hit       (w_id_hit)
  );

  // Falling back to the held value means "no match" leaves ex_rs1 untouched.
  rs1_fwd_resolve u_ex_resolve (
    .i_rs1_idx   (r_inst[19:15]),
    .i_fallback  (r_rs1),
    .i_fwd0_we   (fwd0_we),
    .i_fwd0_rd   (fwd0_rd),
    .i_fwd0_data (fwd0_data),
    .i_fwd1_we   (fwd1_we),
    .i_fwd1_rd   (fwd1_rd),
    .i_fwd1_data (fwd1_data),
    .o_value     (w_ex_rs1),
    .o_hit       (w_ex_hit)
  );

  assign w_refresh = w_ex_hit && reads_rs1(r_inst[6:0], r_inst[19:15]);

  always_comb begin
    w_id_alu_a = w_id_rs1;
    if (id_inst[6:0] == OPC_LUI) begin
      w_id_alu_a = 32'd0;
    end else if (a_sel) begin
      w_id_alu_a = id_pc;
    end
  end

  always_comb begin
    w_upd = UPD_LOAD;
    if (rst) begin
      w_upd = UPD_RESET;
    end else if (flush) begin
      w_upd = UPD_FLUSH;
    end else if (stall) begin
      w_upd = UPD_STALL;
    end
  end

  always_ff @(posedge clk) begin
    case (w_upd)
      UPD_RESET: begin
        r_valid <= 1'b0;
        r_inst  <= NOP_INST;
        r_pc    <= RESET_PC;
        r_alu_a <= 32'd0;
        r_rs1   <= 32'd0;
        r_a_sel <= 1'b0;
      end
      UPD_FLUSH: begin
        r_valid <= 1'b0;
        r_inst  <= NOP_INST;
        r_alu_a <= 32'd0;
        r_rs1   <= 32'd0;
        r_a_sel <= 1'b0;
      end
      UPD_STALL: begin
        if (w_refresh) begin
          r_rs1 <= w_ex_rs1;
          if (!r_a_sel) begin
            r_alu_a <= w_ex_rs1;
          end
        end
      end
      default: begin
        r_valid <= id_valid;
        r_inst  <= id_inst;
        r_pc    <= id_pc;
        r_alu_a <= w_id_alu_a;
        r_rs1   <= w_id_rs1;
        r_a_sel <= a_sel;
      end
    endcase
  end

  assign ex_valid = r_valid;
  assign ex_inst  = r_inst;
  assign ex_pc    = r_pc;
  assign ex_alu_a = r_alu_a;
  assign ex_rs1   = r_rs1;

endmodule

// File: tb/tb_alu_a_operand_stage.sv
// Self-checking bench: directed scenarios with literal expectations, then random
// stimulus compared every cycle against a behavioural model of the stage.
module tb_alu_a_operand_stage;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_ADD   = 7'b0110011;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;

  logic        clk = 1'b0;
  logic        rst, idValid, aSel, stall, flush;
  logic [31:0] idInst, idPc, idRs1Data;
  logic        f0We, f1We;
  logic [4:0]  f0Rd, f1Rd;
  logic [31:0] f0Data, f1Data;
  logic        exValid;
  logic [31:0] exInst, exPc, exAluA, exRs1;

  // model state
  logic        mValid;
  logic [31:0] mInst, mPc, mA, mRs1;
  logic        mASel;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_a_operand_stage dut (
    .clk(clk), .rst(rst), .id_valid(idValid), .id_inst(idInst), .id_pc(idPc),
    .id_rs1_data(idRs1Data), .a_sel(aSel), .stall(stall), .flush(flush),
    .fwd0_we(f0We), .fwd0_rd(f0Rd), .fwd0_data(f0Data),
    .fwd1_we(f1We), .fwd1_rd(f1Rd), .fwd1_data(f1Data),
    .ex_valid(exValid), .ex_inst(exInst), .ex_pc(exPc), .ex_alu_a(exAluA), .ex_rs1(exRs1)
  );

  function automatic logic [31:0] mkInst(input logic [6:0] opc, input logic [4:0] rs1);
    return {12'h0A5, rs1, 3'b000, 5'd1, opc};
  endfunction

  function automatic logic readsRs1(input logic [31:0] inst);
    logic [6:0] opc;
    opc = inst[6:0];
    return inst[19:15] != 0 && opc != OP_LUI && opc != OP_AUIPC && opc != OP_JAL;
  endfunction

  // Returns 1 in hit when a forwarding source supplies register r (x0 never matches).
  function automatic logic [31:0] fwdValue(input logic [4:0] r, input logic [31:0] fallback,
                                           output logic hit);
    hit = 1'b1;
    if (r == 0) begin hit = 1'b0; return 32'd0; end
    if (f0We && f0Rd == r) return f0Data;
    if (f1We && f1Rd == r) return f1Data;
    hit = 1'b0;
    return fallback;
  endfunction

  task automatic modelEdge();
    logic hit;
    logic [31:0] v;
    if (rst) begin
      mValid = 0; mInst = 32'h13; mPc = 32'h2000; mA = 0; mRs1 = 0; mASel = 0;
    end else if (flush) begin
      mValid = 0; mInst = 32'h13; mA = 0; mRs1 = 0; mASel = 0;
    end else if (stall) begin
      if (readsRs1(mInst)) begin
        v = fwdValue(mInst[19:15], mRs1, hit);
        if (hit) begin
          mRs1 = v;
          if (!mASel) mA = v;
        end
      end
    end else begin
      v = fwdValue(idInst[19:15], idRs1Data, hit);
      mValid = idValid; mInst = idInst; mPc = idPc; mRs1 = v; mASel = aSel;
      if (idInst[6:0] == OP_LUI) mA = 0;
      else if (aSel) mA = idPc;
      else mA = v;
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    cmp("ex_valid", {31'd0, exValid}, {31'd0, mValid});
    cmp("ex_inst", exInst, mInst);
    cmp("ex_pc", exPc, mPc);
    cmp("ex_alu_a", exAluA, mA);
    cmp("ex_rs1", exRs1, mRs1);
  endtask

  task automatic setIdle();
    rst = 0; stall = 0; flush = 0; idValid = 1; aSel = 0;
    idInst = 32'h13; idPc = 32'h0; idRs1Data = 0;
    f0We = 0; f0Rd = 0; f0Data = 0; f1We = 0; f1Rd = 0; f1Data = 0;
  endtask

  // Drives one decode instruction (inputs already sit away from the edge).
  task automatic applyStimulus(input logic [6:0] opc, input logic [4:0] rs1,
                               input logic [31:0] pc, input logic [31:0] rfData,
                               input logic sel);
    idInst = mkInst(opc, rs1); idPc = pc; idRs1Data = rfData; aSel = sel;
  endtask

  task automatic tick();
    modelEdge();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    setIdle();

    // reset with stall asserted
    rst = 1; stall = 1;
    tick(); tick();
    cmp("rst_valid", {31'd0, exValid}, 32'd0);
    cmp("rst_inst", exInst, 32'h13);
    cmp("rst_pc", exPc, 32'h2000);
    cmp("rst_alu_a", exAluA, 32'd0);
    setIdle();

    // operand select
    applyStimulus(OP_AUIPC, 5'd9, 32'h2010, 32'h1234, 1'b1); tick();
    cmp("auipc_pc", exAluA, 32'h2010);
    applyStimulus(OP_ADD, 5'd5, 32'h2014, 32'd7, 1'b0); tick();
    cmp("add_rs1", exAluA, 32'd7);
    applyStimulus(OP_LUI, 5'd5, 32'h2018, 32'd9, 1'b0); tick();
    cmp("lui_zero", exAluA, 32'd0);

    // forwarding priority
    f0We = 1; f0Rd = 3; f0Data = 32'hAA; f1We = 1; f1Rd = 3; f1Data = 32'hBB;
    applyStimulus(OP_ADD, 5'd3, 32'h201C, 32'hCC, 1'b0); tick();
    cmp("fwd0_wins", exAluA, 32'hAA);
    f0We = 0; tick();
    cmp("fwd1_only", exAluA, 32'hBB);
    f0We = 1; f0Rd = 0; f1Rd = 0;
    applyStimulus(OP_ADD, 5'd0, 32'h2020, 32'hCC, 1'b0); tick();
    cmp("x0_zero", exAluA, 32'd0);
    setIdle();

    // stall refresh on an ADD
    applyStimulus(OP_ADD, 5'd4, 32'h2024, 32'd1, 1'b0); tick();
    cmp("hold_load", exAluA, 32'd1);
    stall = 1; tick();
    f1We = 1; f1Rd = 4; f1Data = 32'h55; tick();
    cmp("refresh_a", exAluA, 32'h55);
    cmp("refresh_rs1", exRs1, 32'h55);
    cmp("refresh_inst", exInst, mkInst(OP_ADD, 5'd4));
    f1We = 0; tick();
    cmp("refresh_keep", exAluA, 32'h55);

    // same sequence on AUIPC: operand A stays the PC
    stall = 0;
    applyStimulus(OP_AUIPC, 5'd4, 32'h3000, 32'd1, 1'b1); tick();
    stall = 1; tick();
    f1We = 1; tick();
    f1We = 0; tick();
    cmp("auipc_hold", exAluA, 32'h3000);

    // flush beats stall, pc held
    flush = 1; tick();
    cmp("flush_valid", {31'd0, exValid}, 32'd0);
    cmp("flush_inst", exInst, 32'h13);
    cmp("flush_pc", exPc, 32'h3000);
    flush = 0; stall = 0;
    applyStimulus(OP_ADD, 5'd6, 32'h3004, 32'd12, 1'b0); tick();
    cmp("after_flush", exAluA, 32'd12);

    // bubble on decode still captured
    idValid = 0;
    applyStimulus(OP_ADDI, 5'd2, 32'h3008, 32'd3, 1'b0); tick();
    cmp("inv_valid", {31'd0, exValid}, 32'd0);
    cmp("inv_inst", exInst, mkInst(OP_ADDI, 5'd2));
    idValid = 1;
    applyStimulus(OP_ADD, 5'd2, 32'h300C, 32'd8, 1'b0); tick();
    cmp("next_valid", {31'd0, exValid}, 32'd1);
    cmp("next_a", exAluA, 32'd8);

    // random phase
    for (int i = 0; i < 400; i++) begin
      logic [6:0] opcTab [6];
      opcTab = '{OP_LUI, OP_AUIPC, OP_JAL, OP_BR, OP_ADD, OP_ADDI};
      rst   = ($urandom_range(0, 99) < 3);
      flush = ($urandom_range(0, 99) < 10);
      stall = ($urandom_range(0, 99) < 35);
      idValid = $urandom_range(0, 1);
      applyStimulus(opcTab[$urandom_range(0, 5)], 5'($urandom_range(0, 7)),
                    $urandom, $urandom, 1'($urandom_range(0, 1)));
      f0We = $urandom_range(0, 1); f0Rd = 5'($urandom_range(0, 7)); f0Data = $urandom;
      f1We = $urandom_range(0, 1); f1Rd = 5'($urandom_range(0, 7)); f1Data = $urandom;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
